// File: rtl/io_port_responder_if.sv
// rtl/io_port_responder_if.sv - processor strobe/direction and host RX/TX handshake bundle
interface io_port_responder_if #(
    parameter int CW = 3
);
    logic          port_dir;
    logic          port_stb;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] tx_count;
    logic          rx_ovf;
    logic          tx_unf;
    logic          flag_clr;

    modport master (
        output port_dir, port_stb, rx_ready, tx_data, tx_valid, flag_clr,
        input  rx_data, rx_valid, tx_ready, rx_count, tx_count, rx_ovf, tx_unf
    );

    modport slave (
        input  port_dir, port_stb, rx_ready, tx_data, tx_valid, flag_clr,
        output rx_data, rx_valid, tx_ready, rx_count, tx_count, rx_ovf, tx_unf
    );
endinterface

// File: rtl/io_port_responder.sv
// rtl/io_port_responder.sv - board-side partner of the processor IO port: RX/TX FIFOs with host handshake
module io_port_responder #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    inout  wire  [7:0]           io,
    io_port_responder_if.slave   bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic          rx_ovf_q, tx_unf_q;

    logic rx_empty, rx_full, tx_empty, tx_full;
    logic wr_req, rd_req;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic ovf_set, unf_set;
    logic io_oe;
    logic [7:0] io_out;

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL);
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL);

    assign wr_req = bus.port_stb &  bus.port_dir;
    assign rd_req = bus.port_stb & ~bus.port_dir;

    // A host pop frees the head slot in the same edge, so a write into a full RX still fits.
    assign rx_pop  = ~rx_empty & bus.rx_ready;
    assign rx_push = wr_req & (~rx_full | rx_pop);
    assign ovf_set = wr_req & rx_full & ~rx_pop;

    // TX acceptance looks only at fullness; a same-cycle processor pop does not make room.
    assign tx_push = bus.tx_valid & ~tx_full;
    assign tx_pop  = rd_req & ~tx_empty;
    assign unf_set = rd_req & tx_empty;

    assign bus.rx_valid = ~rx_empty;
    assign bus.rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
    assign bus.tx_ready = ~tx_full;
    assign bus.rx_count = rx_cnt;
    assign bus.tx_count = tx_cnt;
    assign bus.rx_ovf   = rx_ovf_q;
    assign bus.tx_unf   = tx_unf_q;

    // Gated by reset so the bus is released immediately, without waiting for a clock.
    assign io_oe  = rst & ~bus.port_dir;
    assign io_out = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];
    assign io     = io_oe ? io_out : 8'hzz;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= io;
        end
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // A set event outranks a coincident clear so no error is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ovf_q <= 1'b0;
            tx_unf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                rx_ovf_q <= 1'b1;
            end else if (bus.flag_clr) begin
                rx_ovf_q <= 1'b0;
            end
            if (unf_set) begin
                tx_unf_q <= 1'b1;
            end else if (bus.flag_clr) begin
                tx_unf_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_io_port_responder.sv
// tb/tb_io_port_responder.sv - table, directed and randomized checks of io_port_responder against a queue model
module tb_io_port_responder;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_io = 8'h00;
    wire  [7:0] io;

    always #5 clk = ~clk;

    assign io = tb_oe ? tb_io : 8'hzz;

    io_port_responder_if #(.CW(CW)) bus();

    io_port_responder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .io(io),
        .bus(bus)
    );

    typedef struct {
        logic       dir;
        logic       stb;
        logic [7:0] pio;
        logic       rdy;
        logic [7:0] td;
        logic       tv;
        logic       fc;
    } vin_t;

    typedef struct {
        vin_t       v;
        int         e_rxc;
        int         e_txc;
        logic [7:0] e_rxd;
        logic [7:0] e_io;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    byte unsigned rx_q[$];
    byte unsigned tx_q[$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;
    int           checks = 0;
    int           errors = 0;
    vec_t         tbl[22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vin_t mk(input bit dir, input bit stb, input logic [7:0] pio, input bit rdy,
                                input logic [7:0] td, input bit tv, input bit fc);
        vin_t v;
        v.dir = dir; v.stb = stb; v.pio = pio; v.rdy = rdy;
        v.td  = td;  v.tv  = tv;  v.fc  = fc;
        return v;
    endfunction

    function automatic vec_t row(input vin_t v, input int rxc, input int txc, input logic [7:0] rxd,
                                 input logic [7:0] eio, input bit ovf, input bit unf);
        vec_t r;
        r.v = v; r.e_rxc = rxc; r.e_txc = txc; r.e_rxd = rxd;
        r.e_io = eio; r.e_ovf = ovf; r.e_unf = unf;
        return r;
    endfunction

    task automatic drive(input vin_t v);
        tb_oe        = v.dir;
        tb_io        = v.pio;
        bus.port_dir = v.dir;
        bus.port_stb = v.stb;
        bus.rx_ready = v.rdy;
        bus.tx_data  = v.td;
        bus.tx_valid = v.tv;
        bus.flag_clr = v.fc;
    endtask

    task automatic comb_check(input vin_t v);
        chk("rx_count", int'(bus.rx_count), rx_q.size());
        chk("tx_count", int'(bus.tx_count), tx_q.size());
        chk("rx_valid", int'(bus.rx_valid), int'(rx_q.size() > 0));
        chk("rx_data", int'(bus.rx_data), (rx_q.size() > 0) ? int'(rx_q[0]) : 0);
        chk("tx_ready", int'(bus.tx_ready), int'(tx_q.size() < DEPTH));
        chk("rx_ovf", int'(bus.rx_ovf), int'(m_ovf));
        chk("tx_unf", int'(bus.tx_unf), int'(m_unf));
        chk("io_oe", int'(dut.io_oe), int'(!v.dir));
        if (!v.dir) begin
            chk("io", int'(io), (tx_q.size() > 0) ? int'(tx_q[0]) : 0);
        end
    endtask

    task automatic model_step(input vin_t v);
        int rxn = rx_q.size();
        int txn = tx_q.size();
        bit rx_pop = (rxn > 0) && v.rdy;
        if (v.fc) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (rx_pop) void'(rx_q.pop_front());
        if (v.stb && v.dir) begin
            if (rxn < DEPTH || rx_pop) rx_q.push_back(v.pio);
            else m_ovf = 1'b1;
        end
        if (v.stb && !v.dir) begin
            if (txn > 0) void'(tx_q.pop_front());
            else m_unf = 1'b1;
        end
        if (v.tv && txn < DEPTH) tx_q.push_back(v.td);
    endtask

    task automatic cycle(input vin_t v);
        drive(v);
        #1;
        comb_check(v);
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input int i);
        cycle(tbl[i].v);
        chk($sformatf("tbl%0d_rxc", i), int'(bus.rx_count), tbl[i].e_rxc);
        chk($sformatf("tbl%0d_txc", i), int'(bus.tx_count), tbl[i].e_txc);
        chk($sformatf("tbl%0d_rxd", i), int'(bus.rx_data), int'(tbl[i].e_rxd));
        chk($sformatf("tbl%0d_ovf", i), int'(bus.rx_ovf), int'(tbl[i].e_ovf));
        chk($sformatf("tbl%0d_unf", i), int'(bus.tx_unf), int'(tbl[i].e_unf));
        if (!tbl[i].v.dir) chk($sformatf("tbl%0d_io", i), int'(io), int'(tbl[i].e_io));
    endtask

    task automatic reset_state_check(input string tag);
        chk({tag, "_rxc"}, int'(bus.rx_count), 0);
        chk({tag, "_txc"}, int'(bus.tx_count), 0);
        chk({tag, "_rxv"}, int'(bus.rx_valid), 0);
        chk({tag, "_txr"}, int'(bus.tx_ready), 1);
        chk({tag, "_rxd"}, int'(bus.rx_data), 0);
        chk({tag, "_ovf"}, int'(bus.rx_ovf), 0);
        chk({tag, "_unf"}, int'(bus.tx_unf), 0);
        chk({tag, "_io_oe"}, int'(dut.io_oe), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // scenario 1: two processor writes then host drains
        tbl[0]  = row(mk(1, 1, 8'hA5, 0, 8'h00, 0, 0), 1, 0, 8'hA5, 8'h00, 0, 0);
        tbl[1]  = row(mk(1, 1, 8'h3C, 0, 8'h00, 0, 0), 2, 0, 8'hA5, 8'h00, 0, 0);
        tbl[2]  = row(mk(1, 0, 8'h00, 1, 8'h00, 0, 0), 1, 0, 8'h3C, 8'h00, 0, 0);
        tbl[3]  = row(mk(1, 0, 8'h00, 1, 8'h00, 0, 0), 0, 0, 8'h00, 8'h00, 0, 0);
        // scenario 2: host fills TX, processor reads out
        tbl[4]  = row(mk(0, 0, 8'h00, 0, 8'h11, 1, 0), 0, 1, 8'h00, 8'h11, 0, 0);
        tbl[5]  = row(mk(0, 0, 8'h00, 0, 8'h22, 1, 0), 0, 2, 8'h00, 8'h11, 0, 0);
        tbl[6]  = row(mk(0, 1, 8'h00, 0, 8'h00, 0, 0), 0, 1, 8'h00, 8'h22, 0, 0);
        tbl[7]  = row(mk(0, 1, 8'h00, 0, 8'h00, 0, 0), 0, 0, 8'h00, 8'h00, 0, 0);
        // scenario 3: RX overflow and full-with-pop acceptance
        tbl[8]  = row(mk(1, 1, 8'h01, 0, 8'h00, 0, 0), 1, 0, 8'h01, 8'h00, 0, 0);
        tbl[9]  = row(mk(1, 1, 8'h02, 0, 8'h00, 0, 0), 2, 0, 8'h01, 8'h00, 0, 0);
        tbl[10] = row(mk(1, 1, 8'h03, 0, 8'h00, 0, 0), 3, 0, 8'h01, 8'h00, 0, 0);
        tbl[11] = row(mk(1, 1, 8'h04, 0, 8'h00, 0, 0), 4, 0, 8'h01, 8'h00, 0, 0);
        tbl[12] = row(mk(1, 1, 8'h05, 0, 8'h00, 0, 0), 4, 0, 8'h01, 8'h00, 1, 0);
        tbl[13] = row(mk(1, 1, 8'h06, 1, 8'h00, 0, 0), 4, 0, 8'h02, 8'h00, 1, 0);
        tbl[14] = row(mk(1, 0, 8'h00, 1, 8'h00, 0, 0), 3, 0, 8'h03, 8'h00, 1, 0);
        tbl[15] = row(mk(1, 0, 8'h00, 1, 8'h00, 0, 0), 2, 0, 8'h04, 8'h00, 1, 0);
        tbl[16] = row(mk(1, 0, 8'h00, 1, 8'h00, 0, 0), 1, 0, 8'h06, 8'h00, 1, 0);
        tbl[17] = row(mk(1, 0, 8'h00, 1, 8'h00, 0, 0), 0, 0, 8'h00, 8'h00, 1, 0);
        tbl[18] = row(mk(1, 0, 8'h00, 0, 8'h00, 0, 1), 0, 0, 8'h00, 8'h00, 0, 0);
        // scenario 4: underflow strobe coinciding with a host push, then clear
        tbl[19] = row(mk(0, 1, 8'h00, 0, 8'h77, 1, 0), 0, 1, 8'h00, 8'h77, 0, 1);
        tbl[20] = row(mk(0, 0, 8'h00, 0, 8'h00, 0, 1), 0, 1, 8'h00, 8'h77, 0, 0);
        tbl[21] = row(mk(0, 1, 8'h00, 0, 8'h00, 0, 0), 0, 0, 8'h00, 8'h00, 0, 0);

        drive(mk(0, 0, 8'h00, 0, 8'h00, 0, 0));
        #2;
        reset_state_check("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) run_row(i);

        // scenario 5: TX wrap with interleaved pops and pushes
        for (int i = 0; i < DEPTH; i++) cycle(mk(0, 0, 8'h00, 0, 8'(8'h40 + i), 1, 0));
        chk("tx_full_ready", int'(bus.tx_ready), 0);
        for (int i = 0; i < 6; i++) begin
            cycle(mk(0, 1, 8'h00, 0, 8'h00, 0, 0));
            cycle(mk(0, 0, 8'h00, 0, 8'(8'h50 + i), 1, 0));
        end
        for (int i = 0; i < DEPTH; i++) cycle(mk(0, 1, 8'h00, 0, 8'h00, 0, 0));

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                     1'($urandom_range(0, 2) == 0), 8'($urandom),
                     1'($urandom_range(0, 4) < 3), 1'($urandom_range(0, 19) == 0)));
        end

        // scenario 6: asynchronous reset mid-stream
        for (int i = 0; i < DEPTH; i++) cycle(mk(1, 0, 8'h00, 1, 8'h00, 0, 0));
        for (int i = 0; i <= DEPTH; i++) cycle(mk(0, 1, 8'h00, 0, 8'h00, 0, 0));
        for (int i = 0; i < 5; i++) cycle(mk(1, 1, 8'(8'h90 + i), 0, 8'(8'hC0 + i), i < 2, 0));
        cycle(mk(1, 0, 8'h00, 1, 8'h00, 0, 0));
        chk("pre_reset_rxc", int'(bus.rx_count), 3);
        chk("pre_reset_txc", int'(bus.tx_count), 2);
        chk("pre_reset_ovf", int'(bus.rx_ovf), 1);
        chk("pre_reset_unf", int'(bus.tx_unf), 1);
        drive(mk(0, 1, 8'h00, 1, 8'h00, 0, 0));
        #1;
        rst = 1'b0;
        #1;
        reset_state_check("async_rst");
        repeat (2) @(posedge clk);
        #1;
        reset_state_check("held_rst");
        rx_q.delete();
        tx_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        drive(mk(1, 0, 8'h00, 0, 8'h00, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) run_row(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- External peripheral on the far end of the processor's 8-bit bidirectional IO port.
- Captures bytes the processor writes out into an RX FIFO, and supplies bytes the processor reads in from a TX FIFO.
- A host-side valid/ready interface drains RX and fills TX.
- Used as the bench/board-side partner of the processor IO subsystem.

Parameters:
DEPTH, 4, entries per FIFO; power of two, >= 2
CW, 3, count width, equal to log2(DEPTH)+1

Ports:
CLK  input  1  system clock; all state updates on the rising edge
RST  input  1  asynchronous, active-low reset
IO  inout  8  processor IO port data bus
PORT_DIR  input  1  1 = processor drives IO (write out); 0 = processor samples IO (read in)
PORT_STB  input  1  one-cycle strobe; processor completes the transfer in the current PORT_DIR direction
RX_DATA  output  8  head of RX FIFO (show-ahead)
RX_VALID  output  1  RX FIFO non-empty
RX_READY  input  1  host pops RX head when RX_VALID & RX_READY
TX_DATA  input  8  host byte to queue for the processor
TX_VALID  input  1  host offers TX_DATA
TX_READY  output  1  TX FIFO not full
RX_COUNT  output  CW  RX occupancy, 0..DEPTH
TX_COUNT  output  CW  TX occupancy, 0..DEPTH
RX_OVF  output  1  sticky: processor write dropped because RX was full
TX_UNF  output  1  sticky: processor read strobed while TX was empty
FLAG_CLR  input  1  synchronous clear of RX_OVF and TX_UNF

Behaviour:
Reset (RST=0, asynchronous):
- FIFO pointers and counts go to 0; RX_OVF=0, TX_UNF=0.
- RX_VALID=0, TX_READY=1, RX_DATA=8'h00.
- IO is high-Z while RST=0, regardless of PORT_DIR.
- Reset mid-transfer discards all queued data; no partial state survives.

IO drive (combinational from PORT_DIR and TX head):
- PORT_DIR=1: IO high-Z.
- PORT_DIR=0 and TX non-empty: IO = TX head.
- PORT_DIR=0 and TX empty: IO = 8'h00.
- The block never drives IO while PORT_DIR=1.

Processor write (PORT_STB=1, PORT_DIR=1):
- IO is sampled at the rising edge.
- RX not full: byte is pushed.
- RX full with no simultaneous host pop: byte is dropped and RX_OVF is set.
- RX full with a simultaneous host pop: push is accepted; count stays DEPTH.

Processor read (PORT_STB=1, PORT_DIR=0):
- TX non-empty: TX head is popped at the edge. The processor samples IO in the strobe cycle, so latency from host push to IO visibility is 1 cycle.
- TX empty: no pop; TX_UNF is set. This holds even if the host pushes in the same cycle; that push still completes and is visible the next cycle.

Host side:
- RX pop occurs when RX_VALID & RX_READY; RX_DATA is valid whenever RX_VALID=1.
- TX push occurs when TX_VALID & TX_READY.
- TX_READY = !TX_full only. No push into a full TX FIFO, even with a simultaneous processor pop.

Pointers and counts:
- Read/write pointers have log2(DEPTH) bits and wrap modulo DEPTH.
- Count is +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Count never exceeds DEPTH and never underflows.

Flags:
- RX_OVF and TX_UNF are sticky until FLAG_CLR=1 at a rising edge.
- If a set event and FLAG_CLR coincide, set wins.
- PORT_STB while RST=0 is ignored.

Test Plan:
1. Reset, then PORT_DIR=1 with IO driven 8'hA5, 8'h3C (one strobe each) -> RX_COUNT=2; RX_DATA=8'hA5 with RX_VALID=1; after a host pop RX_DATA=8'h3C; IO never driven by the block.
2. Host pushes 8'h11, 8'h22, PORT_DIR=0 -> IO=8'h11; strobe -> next cycle IO=8'h22, TX_COUNT=1; strobe -> IO=8'h00, TX_COUNT=0, TX_UNF=0.
3. Fill RX with DEPTH=4 writes 8'h01..8'h04, fifth write 8'h05 with RX_READY=0 -> byte dropped, RX_OVF=1, RX_COUNT=4. Sixth write 8'h06 with a simultaneous host pop -> accepted; drained order is 02,03,04,06.
4. Strobe with PORT_DIR=0 and TX empty while host pushes 8'h77 in the same cycle -> TX_UNF=1, TX_COUNT=1, IO=8'h77 next cycle. FLAG_CLR -> TX_UNF=0.
5. Push 4 TX bytes, pop via strobe 6 times interleaved with 6 more host pushes -> data order preserved across pointer wrap; TX_READY=0 exactly when TX_COUNT=4.
6. Assert RST mid-stream with RX_COUNT=3 and TX_COUNT=2 -> counts immediately 0, flags 0, IO high-Z with no clock edge required. First transfer after release behaves as in scenario 1.
